control_fsm: RTL and testbench

//  Multi-cycle control unit for the R-type MIPS datapath. Consumes op/func_code from
//  the datapath's instruction bits; drives regWrite and alu_ctrl back into it.

---
 rtl/control_fsm_if.sv | 25 ++
 rtl/control_fsm.sv | 93 +++++++++
 tb/tb_control_fsm.sv | 138 +++++++++++++
 3 files changed

// File: rtl/control_fsm_if.sv
// Handshake bundle between the R-type datapath and its multi-cycle control unit.
// The datapath supplies the instruction fields; the control unit returns strobes and status.
interface control_fsm_if #(
    parameter int CNT_W = 16
);
    logic [5:0]       op;
    logic [5:0]       func_code;
    logic             ir_write;
    logic             pc_write;
    logic             regWrite;
    logic [3:0]       alu_ctrl;
    logic             illegal;
    logic [2:0]       state_out;
    logic [CNT_W-1:0] retired;

    modport master (
        output op, func_code,
        input  ir_write, pc_write, regWrite, alu_ctrl, illegal, state_out, retired
    );

    modport slave (
        input  op, func_code,
        output ir_write, pc_write, regWrite, alu_ctrl, illegal, state_out, retired
    );
endinterface

// File: rtl/control_fsm.sv
// Multi-cycle control unit for the R-type MIPS datapath: FETCH/DECODE/EXEC/WB
// sequencing, illegal-instruction trap and a retired-instruction counter.
module control_fsm #(
    parameter int CNT_W = 16
) (
    input  logic         clock,
    input  logic         reset,
    control_fsm_if.slave bus
);
    typedef enum logic [2:0] {
        FETCH   = 3'd0,
        DECODE  = 3'd1,
        EXEC    = 3'd2,
        WB      = 3'd3,
        ILLEGAL = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       alu_reg_q;
    logic [CNT_W-1:0] retired_q;
    logic             ir_write_q, pc_write_q, reg_write_q, illegal_q;
    logic [3:0]       alu_ctrl_q;
    logic             legal;
    logic [3:0]       dec_alu;

    always_comb begin
        legal   = 1'b1;
        dec_alu = alu_reg_q;
        case (bus.func_code)
            6'b100000: dec_alu = 4'b0010;
            6'b100010: dec_alu = 4'b0110;
            6'b100100: dec_alu = 4'b0000;
            6'b100101: dec_alu = 4'b0001;
            6'b101010: dec_alu = 4'b0111;
            6'b100111: dec_alu = 4'b1100;
            default:   legal   = 1'b0;
        endcase
        if (bus.op != 6'b000000) begin
            legal   = 1'b0;
            dec_alu = alu_reg_q;
        end

        case (state_q)
            FETCH:   state_d = DECODE;
            DECODE:  state_d = legal ? EXEC : ILLEGAL;
            EXEC:    state_d = WB;
            default: state_d = FETCH;
        endcase
    end

    // Output flops are loaded with the decode of the state being entered,
    // so each strobe is a clean Moore output of the current state.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= FETCH;
            alu_reg_q   <= 4'b0000;
            retired_q   <= '0;
            ir_write_q  <= 1'b1;
            pc_write_q  <= 1'b1;
            reg_write_q <= 1'b0;
            illegal_q   <= 1'b0;
            alu_ctrl_q  <= 4'b0000;
        end else begin
            state_q <= state_d;
            if (state_q == DECODE && legal) begin
                alu_reg_q <= dec_alu;
            end
            if (state_q == WB) begin
                retired_q <= retired_q + CNT_W'(1);
            end
            ir_write_q  <= (state_d == FETCH);
            pc_write_q  <= (state_d == FETCH);
            reg_write_q <= (state_d == WB);
            illegal_q   <= (state_d == ILLEGAL);
            if (state_d == EXEC) begin
                alu_ctrl_q <= dec_alu;
            end else if (state_d == WB) begin
                alu_ctrl_q <= alu_reg_q;
            end else begin
                alu_ctrl_q <= 4'b0000;
            end
        end
    end

    // Reset masks the strobes immediately, including a write-back in flight.
    assign bus.ir_write  = ir_write_q  & ~reset;
    assign bus.pc_write  = pc_write_q  & ~reset;
    assign bus.regWrite  = reg_write_q & ~reset;
    assign bus.illegal   = illegal_q   & ~reset;
    assign bus.alu_ctrl  = reset ? 4'b0000 : alu_ctrl_q;
    assign bus.state_out = state_q;
    assign bus.retired   = retired_q;
endmodule

// File: tb/tb_control_fsm.sv
// Randomized instruction stream against a per-instruction timeline model of the
// control unit; a 16-bit and a 4-bit counter instance run side by side.
module tb_control_fsm;
    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_err = 0;
    int   exp_ret = 0;

    always #5 clk = ~clk;

    control_fsm_if #(.CNT_W(16)) bus16 ();
    control_fsm_if #(.CNT_W(4))  bus4 ();

    control_fsm #(.CNT_W(16)) dut16 (.clock(clk), .reset(reset), .bus(bus16));
    control_fsm #(.CNT_W(4))  dut4  (.clock(clk), .reset(reset), .bus(bus4));

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference ALU code table for the supported R-type functions.
    function automatic bit lookup(input logic [5:0] o, input logic [5:0] f, output logic [3:0] code);
        code = 4'b0000;
        if (o != 6'd0) return 1'b0;
        case (f)
            6'b100000: code = 4'b0010;
            6'b100010: code = 4'b0110;
            6'b100100: code = 4'b0000;
            6'b100101: code = 4'b0001;
            6'b101010: code = 4'b0111;
            6'b100111: code = 4'b1100;
            default:   return 1'b0;
        endcase
        return 1'b1;
    endfunction

    // One clock cycle: drive inputs, let outputs settle, compare, then advance.
    task automatic step(input logic rst, input logic [5:0] o, input logic [5:0] f,
                        input logic [2:0] st, input logic irw, input logic pcw,
                        input logic rw, input logic [3:0] alu, input logic ill);
        logic [10:0] exp_vec, obs16, obs4;
        reset = rst;
        bus16.op = o; bus16.func_code = f;
        bus4.op  = o; bus4.func_code  = f;
        #1;
        exp_vec = {st, irw, pcw, rw, alu, ill};
        obs16 = {bus16.state_out, bus16.ir_write, bus16.pc_write, bus16.regWrite, bus16.alu_ctrl, bus16.illegal};
        obs4  = {bus4.state_out, bus4.ir_write, bus4.pc_write, bus4.regWrite, bus4.alu_ctrl, bus4.illegal};
        check_val("outs16", 32'(obs16), 32'(exp_vec));
        check_val("outs4", 32'(obs4), 32'(exp_vec));
        check_val("retired16", 32'(bus16.retired), 32'(exp_ret[15:0]));
        check_val("retired4", 32'(bus4.retired), 32'(exp_ret[3:0]));
        @(posedge clk);
        #1;
    endtask

    function automatic logic [5:0] rnd6();
        return 6'($urandom_range(0, 63));
    endfunction

    task automatic do_instr(input logic [5:0] o, input logic [5:0] f, input bit rst_in_wb);
        logic [3:0] code;
        bit legal;
        legal = lookup(o, f, code);
        $display("instr op=%b func=%b legal=%0d alu=%b rst_wb=%0d retired_before=%0d",
                 o, f, legal, code, rst_in_wb, exp_ret);
        step(1'b0, rnd6(), rnd6(), 3'd0, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0);
        step(1'b0, o, f, 3'd1, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0);
        if (legal) begin
            step(1'b0, rnd6(), rnd6(), 3'd2, 1'b0, 1'b0, 1'b0, code, 1'b0);
            if (rst_in_wb) begin
                step(1'b1, rnd6(), rnd6(), 3'd3, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0);
                exp_ret = 0;
            end else begin
                step(1'b0, rnd6(), rnd6(), 3'd3, 1'b0, 1'b0, 1'b1, code, 1'b0);
                exp_ret = (exp_ret + 1) & 32'hFFFF;
            end
        end else begin
            step(1'b0, rnd6(), rnd6(), 3'd4, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b1);
        end
    endtask

    task automatic hold_reset(input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b1, rnd6(), rnd6(), 3'd0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0);
        end
    endtask

    logic [5:0] funcs [6] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b100111};

    initial begin
        logic [5:0] o, f;
        logic [3:0] dummy;
        reset = 1'b1;
        bus16.op = '0; bus16.func_code = '0;
        bus4.op  = '0; bus4.func_code  = '0;
        @(posedge clk);
        #1;
        exp_ret = 0;
        hold_reset(2);

        // Directed: add, then the remaining five back to back.
        for (int i = 0; i < 6; i++) do_instr(6'd0, funcs[i], 1'b0);
        // Illegal opcode (lw) and illegal function code.
        do_instr(6'b100011, 6'b100000, 1'b0);
        do_instr(6'b000000, 6'b000000, 1'b0);
        // Reset hits the write-back of an add.
        do_instr(6'd0, 6'b100000, 1'b1);
        // 17 adds wrap the 4-bit counter 15->0->1.
        for (int i = 0; i < 17; i++) do_instr(6'd0, 6'b100000, 1'b0);

        // Randomized mix of legal and illegal instructions, occasional reset.
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 9) < 7) begin
                o = 6'd0;
                f = funcs[$urandom_range(0, 5)];
            end else if ($urandom_range(0, 1) == 1) begin
                o = 6'($urandom_range(1, 63));
                f = rnd6();
            end else begin
                o = 6'd0;
                f = rnd6();
                while (lookup(o, f, dummy)) f = rnd6();
            end
            do_instr(o, f, ($urandom_range(0, 29) == 0));
        end

        hold_reset(1);
        reset = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
